// File: rtl/adc_sar_osr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_sar_osr_sequencer_if
// Brief    : Control, switch-matrix and result-handshake bundle of the SAR
//            oversampling sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface adc_sar_osr_sequencer_if #(
    parameter int RES_BITS  = 12,
    parameter int OUT_WIDTH = 16
);
    logic                 start_in;
    logic                 continuous_in;
    logic [2:0]           osr_mode_in;
    logic [3:0]           sample_cycles_in;
    logic                 comparator_in;
    logic                 enable_loop_out;
    logic                 sample_out;
    logic                 sample_out_n;
    logic [RES_BITS-1:0]  pswitch_out;
    logic [RES_BITS-1:0]  nswitch_out;
    logic [OUT_WIDTH-1:0] result_out;
    logic                 result_valid_out;
    logic                 result_ready_in;
    logic                 overrun_out;
    logic                 busy_out;

    // Sequencer side
    modport master (
        input  start_in, continuous_in, osr_mode_in, sample_cycles_in,
               comparator_in, result_ready_in,
        output enable_loop_out, sample_out, sample_out_n, pswitch_out,
               nswitch_out, result_out, result_valid_out, overrun_out, busy_out
    );

    // Comparator / consumer side
    modport slave (
        output start_in, continuous_in, osr_mode_in, sample_cycles_in,
               comparator_in, result_ready_in,
        input  enable_loop_out, sample_out, sample_out_n, pswitch_out,
               nswitch_out, result_out, result_valid_out, overrun_out, busy_out
    );
endinterface
`default_nettype wire

// File: rtl/adc_sar_osr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adc_sar_osr_sequencer
// Brief    : SAR sample/convert sequencer with 2^m oversampling accumulator,
//            single-shot/continuous runs and valid/ready result handshake.
// Revision : 1.0 - initial release
// ============================================================================
module adc_sar_osr_sequencer #(
    parameter int RES_BITS     = 12,
    parameter int OSR_MAX_LOG2 = 4,
    parameter int OUT_WIDTH    = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    adc_sar_osr_sequencer_if.master bus
);
    localparam int c_ACC_W = RES_BITS + OSR_MAX_LOG2;
    localparam int c_CNT_W = (OSR_MAX_LOG2 > 0) ? OSR_MAX_LOG2 : 1;
    localparam int c_BIT_W = (RES_BITS > 1) ? $clog2(RES_BITS) : 1;
    localparam logic [RES_BITS-1:0] c_MSB_TRIAL = RES_BITS'(1) << (RES_BITS - 1);

    generate
        if (OUT_WIDTH < c_ACC_W) begin : g_width_check
            $error("adc_sar_osr_sequencer: OUT_WIDTH must be >= RES_BITS + OSR_MAX_LOG2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_ACCUM   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_m;
    logic [3:0]            r_s;
    logic [3:0]            r_sample_cnt;
    logic [c_BIT_W-1:0]    r_bit;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_ACC_W-1:0]    r_acc;
    logic [RES_BITS-1:0]   r_psw;
    logic [OUT_WIDTH-1:0]  r_result;
    logic                  r_valid;
    logic                  r_overrun;

    logic [2:0]            w_m_clamped;
    logic [c_CNT_W-1:0]    w_count_max;
    logic                  w_last_conv;
    logic                  w_sample_done;
    logic                  w_bit_zero;
    logic [c_ACC_W-1:0]    w_sum;
    logic                  w_sample;
    logic                  w_loop_en;
    logic                  w_busy;

    always_comb begin
        w_m_clamped = bus.osr_mode_in;
        if (32'(bus.osr_mode_in) > 32'(OSR_MAX_LOG2)) begin
            w_m_clamped = 3'(OSR_MAX_LOG2);
        end
    end

    assign w_count_max   = c_CNT_W'((32'd1 << r_m) - 32'd1);
    assign w_last_conv   = (r_count == w_count_max);
    assign w_sample_done = (r_sample_cnt == r_s);
    assign w_bit_zero    = (r_bit == '0);
    assign w_sum         = r_acc + c_ACC_W'(r_psw);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        w_loop_en    = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.start_in) begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_sample = 1'b1;
                if (w_sample_done) begin
                    w_state_next = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                w_loop_en = 1'b1;
                if (w_bit_zero) begin
                    w_state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // continuous_in only matters on the publishing accumulate
                if (!w_last_conv || bus.continuous_in) begin
                    w_state_next = ST_SAMPLE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m          <= '0;
            r_s          <= '0;
            r_sample_cnt <= '0;
            r_bit        <= '0;
            r_count      <= '0;
            r_acc        <= '0;
            r_psw        <= '0;
            r_result     <= '0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // A publish later in this block overrides the consume
            if (r_valid && bus.result_ready_in) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_in) begin
                        r_m          <= w_m_clamped;
                        r_s          <= bus.sample_cycles_in;
                        r_acc        <= '0;
                        r_count      <= '0;
                        r_overrun    <= 1'b0;
                        r_sample_cnt <= '0;
                        r_psw        <= '0;
                    end
                end
                ST_SAMPLE: begin
                    r_sample_cnt <= r_sample_cnt + 4'd1;
                    if (w_sample_done) begin
                        r_psw <= c_MSB_TRIAL;
                        r_bit <= c_BIT_W'(RES_BITS - 1);
                    end
                end
                ST_CONVERT: begin
                    r_psw[r_bit] <= bus.comparator_in;
                    if (!w_bit_zero) begin
                        r_psw[r_bit - 1'b1] <= 1'b1;
                        r_bit               <= r_bit - 1'b1;
                    end
                end
                ST_ACCUM: begin
                    r_psw        <= '0;
                    r_sample_cnt <= '0;
                    if (w_last_conv) begin
                        r_result <= OUT_WIDTH'(w_sum);
                        r_valid  <= 1'b1;
                        r_acc    <= '0;
                        r_count  <= '0;
                        if (r_valid && !bus.result_ready_in) begin
                            r_overrun <= 1'b1;
                        end
                    end else begin
                        r_acc   <= w_sum;
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_psw <= '0;
                end
            endcase
        end
    end

    assign bus.enable_loop_out  = w_loop_en;
    assign bus.sample_out       = w_sample;
    assign bus.sample_out_n     = ~w_sample;
    assign bus.busy_out         = w_busy;
    assign bus.pswitch_out      = r_psw;
    assign bus.nswitch_out      = w_loop_en ? ~r_psw : '0;
    assign bus.result_out       = r_result;
    assign bus.result_valid_out = r_valid;
    assign bus.overrun_out      = r_overrun;

endmodule
`default_nettype wire

// File: doc/adc_sar_osr_sequencer.md
Name: adc_sar_osr_sequencer

Overview:
Parametrised SAR conversion sequencer: the next generation of the ADC digital core's control path.
- Merges the sample/convert control and the oversampling accumulator into one block.
- Adds generic resolution, selectable 2^m oversampling, single-shot or continuous mode, and a valid/ready result handshake with overrun detection.
- Sits between the comparator latch / clock-loop generator and the row/column capacitor-matrix decoders.

Parameters:
RES_BITS, 12, SAR resolution; width of pswitch_out/nswitch_out and of each raw conversion code.
OSR_MAX_LOG2, 4, largest supported oversampling exponent m (up to 2^m conversions accumulated).
OUT_WIDTH, 16, result width; must satisfy OUT_WIDTH >= RES_BITS+OSR_MAX_LOG2 (elaboration error otherwise).

Ports:
clk  in  1  digital clock (all state on rising edge)
rst  in  1  asynchronous reset, active high
start_in  in  1  request a conversion run; sampled only in IDLE
continuous_in  in  1  1 = restart automatically after each published result
osr_mode_in  in  3  oversampling exponent m; latched at start
sample_cycles_in  in  4  extra sample cycles S; latched at start
comparator_in  in  1  comparator decision, 1 = keep current trial bit
enable_loop_out  out  1  clock-loop enable, high in CONVERT
sample_out  out  1  matrix/switch sample enable
sample_out_n  out  1  complement of sample_out
pswitch_out  out  RES_BITS  P-matrix SAR register
nswitch_out  out  RES_BITS  N-matrix SAR register
result_out  out  OUT_WIDTH  accumulated result, zero-extended
result_valid_out  out  1  result available
result_ready_in  in  1  consumer accepts result
overrun_out  out  1  sticky: an unconsumed result was overwritten
busy_out  out  1  state != IDLE

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named rst.
- Reset, asynchronous and effective at any time including mid-run: state IDLE.
  - sample_out=0, sample_out_n=1, enable_loop_out=0.
  - pswitch/nswitch=0, result_out=0, result_valid_out=0, overrun_out=0, busy_out=0.
  - Accumulator and conversion counter cleared.
- States:
  - IDLE: if start_in=1, latch m=min(osr_mode_in,OSR_MAX_LOG2) and S. Clear accumulator, counter and overrun_out. Go to SAMPLE.
  - SAMPLE: lasts S+1 cycles. sample_out=1, switch registers 0. On exit, pswitch_out = MSB-only trial (1<<(RES_BITS-1)).
  - CONVERT: lasts RES_BITS cycles, enable_loop_out=1. Cycle k (bit i=RES_BITS-1-k):
    - pswitch[i] <= comparator_in.
    - If i>0, pswitch[i-1] <= 1.
    - nswitch_out = ~pswitch_out while in CONVERT, 0 elsewhere.
  - ACCUM: 1 cycle. acc <= acc + code, zero-extended to RES_BITS+OSR_MAX_LOG2 bits; the sum cannot overflow.
    - If counter < 2^m-1: counter++, go to SAMPLE.
    - Else publish: result_out <= acc+code, result_valid_out <= 1, clear acc/counter.
    - After publishing, go to SAMPLE if continuous_in=1, else to IDLE.
- Run length: a run is 2^m*(S+RES_BITS+2) cycles from the start edge to result_valid_out rising.
- Handshake: result_valid_out falls on the cycle after a sampled valid&ready. result_out holds until the next publish.
- Publish while valid=1 and ready=0 in that cycle: result overwritten, valid stays 1, overrun_out <= 1 (sticky until rst or next start accept).
- Publish in the same cycle as valid&ready: no overrun; valid stays 1 with the new data.
- start_in is ignored while busy. osr_mode_in and sample_cycles_in changes mid-run have no effect.
- continuous_in is sampled only at publish. Dropping it ends the run after the current result.

Test Plan:
- Reset mid-CONVERT (RES_BITS=12): assert rst asynchronously -> all outputs at reset values immediately; busy_out=0; no result_valid_out.
- Single shot, m=0, S=0, comparator model targeting code 0xA5C -> result_valid_out rises 14 cycles after the start edge; result_out=0x0A5C; enable_loop_out high for exactly 12 cycles; sample_out high for 1 cycle.
- m=2, S=3, constant target 0x800 -> 4 conversions; result_out=0x2000; valid after 4*(3+12+2)=68 cycles.
- osr_mode_in=7 -> clamped to m=4; target 0xFFF gives result_out=0xFFF0 after 16 conversions.
- Continuous mode, m=0, result_ready_in held 0 -> second publish sets overrun_out=1 with result_out updated. Repeat with ready pulsed on the publish cycle -> overrun_out stays 0.
- start_in pulsed while busy, and osr_mode_in changed mid-run -> no restart; result uses the latched m.
